// File: rtl/cursor_if.sv
// Bundles the debounced controls going into the cursor controller and the
// cursor/move/select results coming out of it.
interface cursor_if #(
    parameter int XW = 3,
    parameter int YW = 3
);
    logic          en;
    logic          up;
    logic          right;
    logic          down;
    logic          left;
    logic          sel;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;
    logic          move_pulse;
    logic [1:0]    move_dir;
    logic          sel_pulse;
    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;

    modport master (
        output en, up, right, down, left, sel,
        input  cursor_x, cursor_y, move_pulse, move_dir, sel_pulse, sel_x, sel_y
    );

    modport slave (
        input  en, up, right, down, left, sel,
        output cursor_x, cursor_y, move_pulse, move_dir, sel_pulse, sel_x, sel_y
    );
endinterface

// File: rtl/cursor_controller.sv
// Cursor controller: converts debounced direction levels into single-step
// and hold-to-repeat cursor moves on a wrapping COLS x ROWS grid, and turns
// select presses into a strobe carrying the pre-move cursor position.
module cursor_controller #(
    parameter int COLS          = 8,
    parameter int ROWS          = 8,
    parameter int XW            = 3,
    parameter int YW            = 3,
    parameter int CW            = 25,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input logic      clk,
    input logic      rst,
    cursor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    // Direction index doubles as the move_dir encoding: 0 up, 1 right, 2 down, 3 left.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    active_dir, active_n;
    logic [3:0]    prev_dir;
    logic          prev_sel;

    logic [XW-1:0] cur_x, nx, sel_x_q;
    logic [YW-1:0] cur_y, ny, sel_y_q;
    logic          move_pulse_q, sel_pulse_q;
    logic [1:0]    move_dir_q;

    logic [3:0]    dir_lvl, dir_rise;
    logic [1:0]    pri_dir, mv_dir;
    logic          do_move, sel_rise;

    assign dir_lvl  = {bus.left, bus.down, bus.right, bus.up};
    assign dir_rise = dir_lvl & ~prev_dir;
    assign sel_rise = bus.en & bus.sel & ~prev_sel;

    // Fixed priority among simultaneous presses: lowest index (up) wins.
    always_comb begin
        pri_dir = DIR_LEFT;
        if (dir_rise[0])      pri_dir = DIR_UP;
        else if (dir_rise[1]) pri_dir = DIR_RIGHT;
        else if (dir_rise[2]) pri_dir = DIR_DOWN;
    end

    // FSM next-state: fresh press moves immediately, held key repeats after HOLD then every REPEAT.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        active_n = active_dir;
        mv_dir   = active_dir;
        do_move  = 1'b0;
        if (!bus.en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|dir_rise) begin
                        do_move  = 1'b1;
                        mv_dir   = pri_dir;
                        active_n = pri_dir;
                        cnt_n    = '0;
                        state_n  = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    // Only the owning direction matters here; other presses are ignored.
                    if (!dir_lvl[active_dir]) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if ((state == HOLD   && cnt == CW'(HOLD_CYCLES - 1)) ||
                                 (state == REPEAT && cnt == CW'(REPEAT_CYCLES - 1))) begin
                        do_move = 1'b1;
                        cnt_n   = '0;
                        state_n = REPEAT;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Wrapping step of the cursor in the chosen direction.
    always_comb begin
        nx = cur_x;
        ny = cur_y;
        case (mv_dir)
            DIR_UP:    ny = (cur_y == '0) ? YW'(ROWS - 1) : cur_y - 1'b1;
            DIR_RIGHT: nx = (cur_x == XW'(COLS - 1)) ? '0 : cur_x + 1'b1;
            DIR_DOWN:  ny = (cur_y == YW'(ROWS - 1)) ? '0 : cur_y + 1'b1;
            default:   nx = (cur_x == '0) ? XW'(COLS - 1) : cur_x - 1'b1;
        endcase
    end

    // FSM state, repeat counter and owning direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            active_dir <= DIR_UP;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            active_dir <= active_n;
        end
    end

    // Edge-detect history, cursor, move strobe and select capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_dir     <= '0;
            prev_sel     <= 1'b0;
            cur_x        <= '0;
            cur_y        <= '0;
            move_pulse_q <= 1'b0;
            move_dir_q   <= DIR_UP;
            sel_pulse_q  <= 1'b0;
            sel_x_q      <= '0;
            sel_y_q      <= '0;
        end else begin
            prev_dir     <= dir_lvl;
            prev_sel     <= bus.sel;
            move_pulse_q <= do_move;
            sel_pulse_q  <= sel_rise;
            if (do_move) begin
                cur_x      <= nx;
                cur_y      <= ny;
                move_dir_q <= mv_dir;
            end
            // Captures the registered cursor, i.e. the position before any same-edge move.
            if (sel_rise) begin
                sel_x_q <= cur_x;
                sel_y_q <= cur_y;
            end
        end
    end

    assign bus.cursor_x   = cur_x;
    assign bus.cursor_y   = cur_y;
    assign bus.move_pulse = move_pulse_q;
    assign bus.move_dir   = move_dir_q;
    assign bus.sel_pulse  = sel_pulse_q;
    assign bus.sel_x      = sel_x_q;
    assign bus.sel_y      = sel_y_q;
endmodule

// File: tb/tb_cursor_controller.sv
// Bench for cursor_controller: directed walk through the cursor scenarios
// followed by random key activity, all compared cycle by cycle against a
// key-hold-time reference model.
module tb_cursor_controller;
    localparam int COLS = 4, ROWS = 3, XW = 2, YW = 2, CW = 4;
    localparam int HOLD = 4, REPEAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0, passed = 0;

    cursor_if #(.XW(XW), .YW(YW)) bus ();

    cursor_controller #(
        .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .CW(CW),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: position plus "which key owns the cursor and for how many edges it has been held".
    int       mx, my, mdir, msx, msy, owner, held;
    bit       mmp, msp, mprevs;
    bit [3:0] mprev;

    task automatic model_reset();
        mx = 0; my = 0; mdir = 0; msx = 0; msy = 0;
        mmp = 0; msp = 0; mprev = '0; mprevs = 0;
        owner = -1; held = 0;
    endtask

    task automatic model_move(input int d);
        case (d)
            0: my = (my == 0) ? ROWS - 1 : my - 1;
            1: mx = (mx == COLS - 1) ? 0 : mx + 1;
            2: my = (my == ROWS - 1) ? 0 : my + 1;
            default: mx = (mx == 0) ? COLS - 1 : mx - 1;
        endcase
        mdir = d;
        mmp  = 1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("cursor_x",   int'(bus.cursor_x),   mx);
        chk("cursor_y",   int'(bus.cursor_y),   my);
        chk("move_pulse", int'(bus.move_pulse), int'(mmp));
        chk("move_dir",   int'(bus.move_dir),   mdir);
        chk("sel_pulse",  int'(bus.sel_pulse),  int'(msp));
        chk("sel_x",      int'(bus.sel_x),      msx);
        chk("sel_y",      int'(bus.sel_y),      msy);
    endtask

    // One clock edge: predict from the applied inputs, then compare after the edge.
    task automatic tick();
        bit [3:0] lv, rise;
        bit       srise;
        int       d;
        lv    = {bus.left, bus.down, bus.right, bus.up};
        rise  = lv & ~mprev;
        srise = bus.sel & ~mprevs;
        @(posedge clk);
        mmp = 0;
        msp = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (bus.en && srise) begin
                msp = 1; msx = mx; msy = my;
            end
            if (!bus.en) begin
                owner = -1;
            end else if (owner >= 0) begin
                if (lv[owner]) begin
                    held++;
                    if (held == HOLD || (held > HOLD && (held - HOLD) % REPEAT == 0))
                        model_move(owner);
                end else begin
                    owner = -1;
                end
            end else if (rise != 0) begin
                d = rise[0] ? 0 : rise[1] ? 1 : rise[2] ? 2 : 3;
                model_move(d);
                owner = d;
                held  = 0;
            end
            mprev  = lv;
            mprevs = bus.sel;
        end
        #1;
        check_all();
    endtask

    task automatic set_dirs(input bit u, input bit r, input bit dn, input bit l);
        bus.up = u; bus.right = r; bus.down = dn; bus.left = l;
    endtask

    // Press for one cycle, then release for one cycle.
    task automatic tap(input int d);
        set_dirs(d == 0, d == 1, d == 2, d == 3);
        tick();
        set_dirs(0, 0, 0, 0);
        tick();
    endtask

    initial begin
        model_reset();
        bus.en = 1'b1;
        bus.sel = 1'b0;
        set_dirs(0, 0, 0, 0);

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single tap right from the origin
        set_dirs(0, 1, 0, 0);
        tick();
        chk("t1_pulse", int'(bus.move_pulse), 1);
        chk("t1_dir",   int'(bus.move_dir),   1);
        set_dirs(0, 0, 0, 0);
        repeat (4) tick();
        chk("t1_x", int'(bus.cursor_x), 1);
        chk("t1_y", int'(bus.cursor_y), 0);

        // Wrap-around on right, up and left
        tap(1); tap(1);
        tap(1);
        chk("t2_right_wrap_x", int'(bus.cursor_x), 0);
        tap(0);
        chk("t2_up_wrap_y", int'(bus.cursor_y), 2);
        tap(3);
        chk("t2_left_wrap_x", int'(bus.cursor_x), 3);

        // Hold right 10 cycles from (0,0): moves on cycles 0, 4, 6, 8
        tap(1); tap(2);
        set_dirs(0, 1, 0, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("t3_pulse", int'(bus.move_pulse), (c == 0 || c == 4 || c == 6 || c == 8) ? 1 : 0);
        end
        set_dirs(0, 0, 0, 0);
        tick();
        chk("t3_x", int'(bus.cursor_x), 0);

        // Simultaneous up+left from (1,1): up wins, left stays ignored after up is released
        tap(1); tap(2);
        set_dirs(1, 0, 0, 1);
        tick();
        set_dirs(0, 0, 0, 1);
        repeat (8) tick();
        set_dirs(0, 0, 0, 0);
        tick();
        chk("t4_x", int'(bus.cursor_x), 1);
        chk("t4_y", int'(bus.cursor_y), 0);

        // Select on the same edge as a move reports the pre-move position
        tap(1); tap(2);
        set_dirs(0, 1, 0, 0);
        bus.sel = 1'b1;
        tick();
        chk("t5_sel_pulse", int'(bus.sel_pulse), 1);
        chk("t5_sel_x",     int'(bus.sel_x),     2);
        chk("t5_x",         int'(bus.cursor_x),  3);
        set_dirs(0, 0, 0, 0);
        bus.sel = 1'b0;
        tick();

        // Reset during repeat, then disabled taps, then re-enable
        set_dirs(0, 1, 0, 0);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_dirs(0, 0, 0, 0);
        bus.en = 1'b0;
        for (int d = 0; d < 4; d++) tap(d);
        bus.sel = 1'b1; tick(); bus.sel = 1'b0; tick();
        chk("t6_x", int'(bus.cursor_x), 0);
        chk("t6_y", int'(bus.cursor_y), 0);
        bus.en = 1'b1;
        tap(2);
        chk("t6_down_y", int'(bus.cursor_y), 1);

        // Random key activity with occasional disable and reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) bus.up    = ~bus.up;
            if ($urandom_range(0, 7) == 0) bus.right = ~bus.right;
            if ($urandom_range(0, 7) == 0) bus.down  = ~bus.down;
            if ($urandom_range(0, 7) == 0) bus.left  = ~bus.left;
            if ($urandom_range(0, 3) == 0) bus.sel   = ~bus.sel;
            bus.en = ($urandom_range(0, 19) != 0);
            rst    = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
